// File: rtl/mem_arbiter.sv
// Two-requester (fetch / load-store) arbiter onto a single memory port.
// Round-robin on ties, one transaction in flight, registered responses.
module mem_arbiter #(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64,
  parameter int MASK_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req_valid,
  output logic              if_req_ready,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_resp_valid,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              ls_req_valid,
  output logic              ls_req_ready,
  input  logic [ADDR_W-1:0] ls_addr,
  input  logic              ls_wen,
  input  logic [DATA_W-1:0] ls_wdata,
  input  logic [MASK_W-1:0] ls_wmask,
  output logic              ls_resp_valid,
  output logic [DATA_W-1:0] ls_rdata,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_wen,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [MASK_W-1:0] mem_wmask,
  input  logic              mem_resp_valid,
  input  logic [DATA_W-1:0] mem_rdata
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;
  localparam logic OWN_IF = 1'b0;
  localparam logic OWN_LS = 1'b1;

  state_t            r_state;
  logic              r_last_grant;
  logic              r_owner;
  logic              r_mem_req_valid;
  logic [ADDR_W-1:0] r_addr;
  logic              r_wen;
  logic [DATA_W-1:0] r_wdata;
  logic [MASK_W-1:0] r_wmask;
  logic              r_if_resp_valid;
  logic              r_ls_resp_valid;
  logic [DATA_W-1:0] r_if_rdata;
  logic [DATA_W-1:0] r_ls_rdata;
  logic              w_grant_if;
  logic              w_grant_ls;

  // Ties go to whichever side did not win last; the two grants are mutually exclusive.
  assign w_grant_if = (r_state == IDLE) && if_req_valid &&
                      (!ls_req_valid || (r_last_grant == OWN_LS));
  assign w_grant_ls = (r_state == IDLE) && ls_req_valid &&
                      (!if_req_valid || (r_last_grant == OWN_IF));

  assign if_req_ready  = w_grant_if;
  assign ls_req_ready  = w_grant_ls;
  assign mem_req_valid = r_mem_req_valid;
  assign mem_addr      = r_addr;
  assign mem_wen       = r_wen;
  assign mem_wdata     = r_wdata;
  assign mem_wmask     = r_wmask;
  assign if_resp_valid = r_if_resp_valid;
  assign ls_resp_valid = r_ls_resp_valid;
  assign if_rdata      = r_if_rdata;
  assign ls_rdata      = r_ls_rdata;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state         <= IDLE;
      r_last_grant    <= OWN_LS;
      r_owner         <= OWN_IF;
      r_mem_req_valid <= 1'b0;
      r_addr          <= '0;
      r_wen           <= 1'b0;
      r_wdata         <= '0;
      r_wmask         <= '0;
      r_if_resp_valid <= 1'b0;
      r_ls_resp_valid <= 1'b0;
      r_if_rdata      <= '0;
      r_ls_rdata      <= '0;
    end else begin
      r_if_resp_valid <= 1'b0;
      r_ls_resp_valid <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_grant_if) begin
            r_addr          <= if_addr;
            r_wen           <= 1'b0;
            r_wdata         <= '0;
            r_wmask         <= '0;
            r_owner         <= OWN_IF;
            r_mem_req_valid <= 1'b1;
            r_state         <= REQ;
          end else if (w_grant_ls) begin
            r_addr          <= ls_addr;
            r_wen           <= ls_wen;
            r_wdata         <= ls_wdata;
            r_wmask         <= ls_wen ? ls_wmask : '0;
            r_owner         <= OWN_LS;
            r_mem_req_valid <= 1'b1;
            r_state         <= REQ;
          end
        end
        REQ: begin
          if (mem_req_ready) begin
            r_mem_req_valid <= 1'b0;
            r_state         <= WAIT;
          end
        end
        WAIT: begin
          if (mem_resp_valid) begin
            if (r_owner == OWN_IF) begin
              r_if_rdata      <= mem_rdata;
              r_if_resp_valid <= 1'b1;
            end else begin
              r_ls_rdata      <= mem_rdata;
              r_ls_resp_valid <= 1'b1;
            end
            r_last_grant <= r_owner;
            r_state      <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: inputs change 1 time unit after the rising edge,
// outputs are checked 2 time units after it.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req_valid, if_req_ready, if_resp_valid;
  logic [63:0] if_addr, if_rdata;
  logic        ls_req_valid, ls_req_ready, ls_wen, ls_resp_valid;
  logic [63:0] ls_addr, ls_wdata, ls_rdata;
  logic [7:0]  ls_wmask;
  logic        mem_req_valid, mem_req_ready, mem_wen, mem_resp_valid;
  logic [63:0] mem_addr, mem_wdata, mem_rdata;
  logic [7:0]  mem_wmask;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_arbiter #(.ADDR_W(64), .DATA_W(64), .MASK_W(8)) dut (
    .clk(clk), .rst(rst),
    .if_req_valid(if_req_valid), .if_req_ready(if_req_ready), .if_addr(if_addr),
    .if_resp_valid(if_resp_valid), .if_rdata(if_rdata),
    .ls_req_valid(ls_req_valid), .ls_req_ready(ls_req_ready), .ls_addr(ls_addr),
    .ls_wen(ls_wen), .ls_wdata(ls_wdata), .ls_wmask(ls_wmask),
    .ls_resp_valid(ls_resp_valid), .ls_rdata(ls_rdata),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_addr(mem_addr),
    .mem_wen(mem_wen), .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
    .mem_resp_valid(mem_resp_valid), .mem_rdata(mem_rdata)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance to 1 unit after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Starts in an IDLE cycle with requests already driven; ends in the response
  // cycle (N+3), which is also the next possible accept cycle.
  task automatic do_txn(input bit exp_if, input logic [63:0] rdata);
    #1;
    chk("rdy_if", {63'd0, if_req_ready}, {63'd0, exp_if});
    chk("rdy_ls", {63'd0, ls_req_ready}, {63'd0, !exp_if});
    tick(); #1;
    chk("txn_mreq", {63'd0, mem_req_valid}, 64'd1);
    chk("txn_addr", mem_addr, exp_if ? if_addr : ls_addr);
    chk("txn_rdy_busy", {62'd0, if_req_ready, ls_req_ready}, 64'd0);
    tick();
    mem_resp_valid = 1'b1;
    mem_rdata = rdata;
    #1;
    chk("txn_mreq_wait", {63'd0, mem_req_valid}, 64'd0);
    chk("txn_rdy_wait", {62'd0, if_req_ready, ls_req_ready}, 64'd0);
    tick();
    mem_resp_valid = 1'b0;
    #1;
    chk("txn_resp", {62'd0, if_resp_valid, ls_resp_valid}, exp_if ? 64'd2 : 64'd1);
    chk("txn_rdata", exp_if ? if_rdata : ls_rdata, rdata);
  endtask

  initial begin
    rst = 1'b1;
    if_req_valid = 0; if_addr = '0;
    ls_req_valid = 0; ls_addr = '0; ls_wen = 0; ls_wdata = '0; ls_wmask = '0;
    mem_req_ready = 0; mem_resp_valid = 0; mem_rdata = '0;
    tick(); tick(); #1;
    chk("rst_outs", {57'd0, if_req_ready, ls_req_ready, if_resp_valid, ls_resp_valid,
                     mem_req_valid, mem_wen, 1'b0}, 64'd0);
    chk("rst_addr", mem_addr, 64'd0);
    chk("rst_wmask", {56'd0, mem_wmask}, 64'd0);
    chk("rst_rdata", if_rdata | ls_rdata, 64'd0);

    // Single fetch with request inputs scrambled after acceptance.
    tick();
    rst = 0;
    if_req_valid = 1; if_addr = 64'h8000_0000; mem_req_ready = 1;
    #1;
    chk("f_rdy", {62'd0, if_req_ready, ls_req_ready}, 64'd2);
    tick();
    if_req_valid = 0; if_addr = 64'h1234;
    #1;
    chk("f_mreq", {63'd0, mem_req_valid}, 64'd1);
    chk("f_addr", mem_addr, 64'h8000_0000);
    chk("f_wen_mask", {55'd0, mem_wen, mem_wmask}, 64'd0);
    tick();
    mem_resp_valid = 1; mem_rdata = 64'h0000_0413_0000_0297;
    #1;
    chk("f_mreq_wait", {63'd0, mem_req_valid}, 64'd0);
    tick();
    mem_resp_valid = 0; mem_rdata = '0;
    #1;
    chk("f_resp", {62'd0, if_resp_valid, ls_resp_valid}, 64'd2);
    chk("f_rdata", if_rdata, 64'h0000_0413_0000_0297);
    tick(); #1;
    chk("f_pulse_end", {62'd0, if_resp_valid, ls_resp_valid}, 64'd0);
    chk("f_rdata_hold", if_rdata, 64'h0000_0413_0000_0297);

    // Tie after reset: IF first, then alternation while both stay valid.
    rst = 1; tick(); rst = 0;
    if_req_valid = 1; if_addr = 64'h100;
    ls_req_valid = 1; ls_addr = 64'h200; ls_wen = 0;
    do_txn(1'b1, 64'hA1);
    do_txn(1'b0, 64'hB1);
    do_txn(1'b1, 64'hA2);
    do_txn(1'b0, 64'hB2);

    // Store.
    if_req_valid = 0;
    ls_req_valid = 1; ls_wen = 1; ls_addr = 64'h8000_1004;
    ls_wdata = 64'hDEAD_BEEF_0000_0000; ls_wmask = 8'hF0;
    #1;
    chk("st_rdy", {62'd0, if_req_ready, ls_req_ready}, 64'd1);
    tick();
    ls_req_valid = 0; ls_addr = '0; ls_wdata = '0; ls_wmask = '0; ls_wen = 0;
    #1;
    chk("st_addr", mem_addr, 64'h8000_1004);
    chk("st_wdata", mem_wdata, 64'hDEAD_BEEF_0000_0000);
    chk("st_wen_mask", {55'd0, mem_wen, mem_wmask}, {55'd0, 1'b1, 8'hF0});
    tick();
    mem_resp_valid = 1; mem_rdata = 64'h55;
    tick();
    mem_resp_valid = 0;
    #1;
    chk("st_resp", {62'd0, if_resp_valid, ls_resp_valid}, 64'd1);
    tick(); #1;
    chk("st_pulse_end", {63'd0, ls_resp_valid}, 64'd0);

    // Backpressure: both valid, last grant LS, so IF wins and then stalls.
    if_req_valid = 1; if_addr = 64'hC0C0; ls_req_valid = 1; ls_addr = 64'hD0D0;
    mem_req_ready = 0;
    #1;
    chk("bp_rdy", {62'd0, if_req_ready, ls_req_ready}, 64'd2);
    for (int i = 0; i < 5; i++) begin
      tick(); #1;
      chk("bp_mreq", {63'd0, mem_req_valid}, 64'd1);
      chk("bp_addr", mem_addr, 64'hC0C0);
      chk("bp_rdy_low", {62'd0, if_req_ready, ls_req_ready}, 64'd0);
    end
    mem_req_ready = 1;
    tick();
    if_req_valid = 0; ls_req_valid = 0;
    mem_resp_valid = 1; mem_rdata = 64'hCAFE;
    tick();
    mem_resp_valid = 0;
    #1;
    chk("bp_resp", {62'd0, if_resp_valid, ls_resp_valid}, 64'd2);
    chk("bp_rdata", if_rdata, 64'hCAFE);

    // Stray response while IDLE.
    tick();
    mem_resp_valid = 1; mem_rdata = 64'hBAD;
    tick(); #1;
    chk("stray_resp", {61'd0, if_resp_valid, ls_resp_valid, mem_req_valid}, 64'd0);
    chk("stray_if_rdata", if_rdata, 64'hCAFE);
    chk("stray_ls_rdata", ls_rdata, 64'h55);
    mem_resp_valid = 0;
    tick();
    if_req_valid = 1; if_addr = 64'hE000;
    do_txn(1'b1, 64'h77);

    // Reset while in WAIT; the late response must be dropped.
    if_req_valid = 0;
    tick();
    if_req_valid = 1; if_addr = 64'hF000;
    #1;
    chk("rw_rdy", {62'd0, if_req_ready, ls_req_ready}, 64'd2);
    tick();
    if_req_valid = 0;
    tick();
    rst = 1;
    tick();
    rst = 0;
    mem_resp_valid = 1; mem_rdata = 64'h999;
    tick(); #1;
    chk("rw_no_resp", {61'd0, if_resp_valid, ls_resp_valid, mem_req_valid}, 64'd0);
    mem_resp_valid = 0;
    tick(); #1;
    chk("rw_no_resp2", {62'd0, if_resp_valid, ls_resp_valid}, 64'd0);
    if_req_valid = 1; ls_req_valid = 1;
    #1;
    chk("rw_tie_if", {62'd0, if_req_ready, ls_req_ready}, 64'd2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameters SHALL be: ADDR_W, default 64, address width; DATA_W, default 64, data width; MASK_W, default 8, byte-mask width (DATA_W/8).
REQ-002 The port list SHALL be, one per line:
 clk  in  1  single clock, all state updates on rising edge
 rst  in  1  synchronous reset, active-high
 if_req_valid  in  1  fetch read request
 if_req_ready  out  1  fetch request accepted this cycle
 if_addr  in  ADDR_W  fetch address
 if_resp_valid  out  1  fetch data valid, one-cycle pulse
 if_rdata  out  DATA_W  fetch read data
 ls_req_valid  in  1  load/store request
 ls_req_ready  out  1  load/store request accepted this cycle
 ls_addr  in  ADDR_W  load/store address
 ls_wen  in  1  1 = write, 0 = read
 ls_wdata  in  DATA_W  store data
 ls_wmask  in  MASK_W  store byte mask
 ls_resp_valid  out  1  load data / store completion, one-cycle pulse
 ls_rdata  out  DATA_W  load read data
 mem_req_valid  out  1  request to shared memory port
 mem_req_ready  in  1  memory accepts request
 mem_addr  out  ADDR_W  memory address
 mem_wen  out  1  memory write enable
 mem_wdata  out  DATA_W  memory write data
 mem_wmask  out  MASK_W  memory byte mask; 0 on reads
 mem_resp_valid  in  1  memory response valid
 mem_rdata  in  DATA_W  memory read data

Function
REQ-003 The FSM SHALL have exactly three states: IDLE, REQ, WAIT.
REQ-004 In IDLE with exactly one req_valid high, that requester SHALL be granted; its req_ready SHALL be high combinationally that cycle.
REQ-005 In IDLE with both valid, grant SHALL go to the requester not granted last (round-robin via a 1-bit last_grant register); the loser's ready SHALL stay low.
REQ-006 req_ready outputs SHALL be low in REQ and WAIT, and at most one SHALL be high in any cycle.
REQ-007 On grant, addr, wen, wdata and wmask SHALL be latched (fetch: wen=0, wmask=0), the grant owner recorded, and the state SHALL move to REQ.
REQ-008 In REQ, mem_req_valid SHALL be 1 and mem_addr/wen/wdata/wmask SHALL hold the latched values, stable until mem_req_ready; mem_req_valid SHALL be 0 in IDLE and WAIT.
REQ-009 REQ→WAIT SHALL occur on the cycle mem_req_valid && mem_req_ready.
REQ-010 In WAIT, on mem_resp_valid, mem_rdata SHALL be registered into the owner's rdata, the owner's resp_valid SHALL pulse high for exactly the next cycle, last_grant SHALL be updated to the owner, and the state SHALL move to IDLE.
REQ-011 Writes SHALL also produce one ls_resp_valid pulse (completion); ls_rdata content for writes is don't-care.
REQ-012 The non-owner's resp_valid SHALL remain 0; rdata outputs SHALL hold their last value when not pulsed.
REQ-013 mem_resp_valid outside WAIT SHALL be ignored, with no state or output change.
REQ-014 Minimum latency SHALL be accept at cycle N, mem_req_valid at N+1, mem_resp_valid at N+2, and resp_valid at N+3; the next grant may be issued in cycle N+3.
REQ-015 Requester inputs SHALL be sampled only in the accept cycle; later changes SHALL NOT alter the in-flight transaction.

Reset
REQ-016 While rst=1 at a clock edge: state SHALL be IDLE, last_grant SHALL be LS (so the first tie goes to IF), all valid/ready/resp outputs SHALL be 0, latched fields and rdata SHALL be 0.
REQ-017 Reset mid-transaction (REQ or WAIT) SHALL abandon it: no resp_valid pulse, and any late mem_resp_valid SHALL be ignored.

Verification
REQ-018 The bench SHALL cover these scenarios:
 - Single fetch: if_addr=0x80000000, mem_req_ready=1, mem_rdata=0x00000413_00000297 one cycle later → if_resp_valid pulse at N+3 with if_rdata=that value; ls_resp_valid stays 0.
 - Tie after reset: both valid same cycle → IF granted first, LS granted in the next IDLE; with both held valid, grants alternate IF, LS, IF, LS.
 - Store: ls_wen=1, ls_addr=0x80001004, ls_wdata=0xDEADBEEF_00000000, ls_wmask=0xF0 → mem_* carry those exact values, mem_wen=1, one ls_resp_valid pulse.
 - Backpressure: mem_req_ready low for 5 cycles → mem_req_valid and mem_addr stay stable all 5 cycles; neither req_ready rises.
 - Stray response: mem_resp_valid=1 while IDLE → no resp_valid and no state change.
 - Reset in WAIT: rst=1 for one cycle, then mem_resp_valid=1 → no resp_valid pulse; IF wins the next tie.
